// File: rtl/memory_arb_if.sv
`default_nettype none
// memory_arb_if: per-port request/response bundle between bus masters and memory_arb.
// Rev 1.0
interface memory_arb_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int PORTS      = 2
);
  logic [PORTS-1:0]            valid;
  logic [PORTS-1:0]            wr_rd;
  logic [PORTS*ADDR_WIDTH-1:0] addr;
  logic [PORTS*WIDTH-1:0]      wdata;
  logic [PORTS*WIDTH/8-1:0]    be;
  logic [PORTS-1:0]            ready;
  logic [PORTS-1:0]            rvalid;
  logic [PORTS*WIDTH-1:0]      rdata;
  logic [PORTS-1:0]            err;

  modport master (
    output valid, wr_rd, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/memory_arb.sv
`default_nettype none
// memory_arb: round-robin shared scratchpad with byte-enable writes, RD_LAT response
// pipeline, out-of-range error reporting and post-reset zero-fill.  Rev 1.0
module memory_arb #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int PORTS      = 2,
  parameter int RD_LAT     = 1
) (
  input wire logic    clk,
  input wire logic    res,
  memory_arb_if.slave bus
);
  localparam int c_PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int c_BYTES = WIDTH / 8;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [c_PTR_W-1:0]    r_rr, w_rr_nxt;
  logic [PORTS-1:0]      w_grant;
  logic [c_PTR_W-1:0]    w_win;
  logic                  w_found;
  logic [c_PTR_W:0]      w_sum;

  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_wdata;
  logic [c_BYTES-1:0]    w_sel_be;
  logic                  w_in_range;
  logic [WIDTH-1:0]      w_rd_word;

  logic [WIDTH-1:0]      mem [DEPTH];

  logic [RD_LAT-1:0]     r_pv;
  logic [RD_LAT-1:0]     r_perr;
  logic [c_PTR_W-1:0]    r_pport [RD_LAT];
  logic [WIDTH-1:0]      r_pdata [RD_LAT];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr;
    w_grant     = '0;
    w_win       = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    case (r_state)
      INIT: begin
        if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        // first valid port at or above the pointer, wrapping modulo PORTS
        for (int i = 0; i < PORTS; i++) begin
          w_sum = {1'b0, r_rr} + (c_PTR_W + 1)'(i);
          if (w_sum >= (c_PTR_W + 1)'(PORTS)) begin
            w_sum = w_sum - (c_PTR_W + 1)'(PORTS);
          end
          if (!w_found && bus.valid[w_sum[c_PTR_W-1:0]]) begin
            w_found                      = 1'b1;
            w_win                        = w_sum[c_PTR_W-1:0];
            w_grant[w_sum[c_PTR_W-1:0]] = 1'b1;
          end
        end
        if (w_found) begin
          w_rr_nxt = (w_win == c_PTR_W'(PORTS - 1)) ? '0 : w_win + 1'b1;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_wr    = bus.wr_rd[p];
        w_sel_addr  = bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = bus.wdata[p*WIDTH +: WIDTH];
        w_sel_be    = bus.be[p*c_BYTES +: c_BYTES];
      end
    end
  end

  assign w_in_range = (32'(w_sel_addr) < DEPTH);
  assign w_rd_word  = w_in_range ? mem[w_sel_addr] : '0;
  assign bus.ready  = w_grant;

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      mem[r_cnt] <= '0;
    end else if (w_found && w_sel_wr && w_in_range) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_sel_be[b]) begin
          mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
        end
      end
    end
  end

  // The response travels with its port number so only the accepting port sees it.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pv   <= '0;
      r_perr <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pport[i] <= '0;
        r_pdata[i] <= '0;
      end
    end else begin
      r_pv[0]    <= w_found;
      r_pport[0] <= w_win;
      r_perr[0]  <= w_found && !w_in_range;
      r_pdata[0] <= (w_found && !w_sel_wr) ? w_rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pport[i] <= r_pport[i-1];
        r_perr[i]  <= r_perr[i-1];
        r_pdata[i] <= r_pdata[i-1];
      end
    end
  end

  generate
    for (genvar p = 0; p < PORTS; p++) begin : g_resp
      logic w_hit;
      assign w_hit                      = r_pv[RD_LAT-1] && (r_pport[RD_LAT-1] == c_PTR_W'(p));
      assign bus.rvalid[p]              = w_hit;
      assign bus.err[p]                 = w_hit && r_perr[RD_LAT-1];
      assign bus.rdata[p*WIDTH +: WIDTH] = w_hit ? r_pdata[RD_LAT-1] : '0;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_memory_arb.sv
`default_nettype none
// tb_memory_arb: directed and randomized checks of memory_arb against a transaction-level model.
// Rev 1.0
module tb_memory_arb;
  localparam int W  = 16;
  localparam int D  = 48;
  localparam int AW = $clog2(D);
  localparam int P  = 2;
  localparam int L  = 4;
  localparam int BW = W / 8;

  typedef struct {
    int           due;
    int           port;
    logic [W-1:0] data;
    logic         err;
  } resp_t;

  logic clk = 1'b0;
  logic res = 1'b1;

  logic [P-1:0]    req_v  = '0;
  logic [P-1:0]    req_wr = '0;
  logic [P*AW-1:0] req_a  = '0;
  logic [P*W-1:0]  req_d  = '0;
  logic [P*BW-1:0] req_be = '0;

  memory_arb_if #(.WIDTH(W), .DEPTH(D), .PORTS(P)) bus ();

  assign bus.valid = req_v;
  assign bus.wr_rd = req_wr;
  assign bus.addr  = req_a;
  assign bus.wdata = req_d;
  assign bus.be    = req_be;

  memory_arb #(.WIDTH(W), .DEPTH(D), .PORTS(P), .RD_LAT(L)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           passed = 0;
  int           failed = 0;
  int           cycle = 0;
  int           rr_m = 0;
  int           init_left = D;
  logic [W-1:0] mdl [D];
  resp_t        q [$];
  int           grant_log [$];
  logic [P-1:0] acc = '0;
  logic [W-1:0] last_rdata [P];
  logic         last_err [P];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock cycle: predict grant and response, compare, then advance the model.
  task automatic step();
    int           win;
    int           idx;
    int           a;
    logic [P-1:0] exp_ready;
    logic [P-1:0] exp_rv;
    logic [P-1:0] exp_er;
    logic [P*W-1:0] exp_rd;
    resp_t        r;
    @(negedge clk);
    win = -1;
    exp_ready = '0;
    if (!res && init_left == 0) begin
      for (int i = 0; i < P; i++) begin
        idx = (rr_m + i) % P;
        if (win < 0 && req_v[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("ready", bus.ready, exp_ready);

    exp_rv = '0; exp_er = '0; exp_rd = '0;
    if (q.size() > 0 && q[0].due == cycle) begin
      r = q.pop_front();
      exp_rv[r.port] = 1'b1;
      exp_er[r.port] = r.err;
      exp_rd[r.port*W +: W] = r.data;
    end
    check("rvalid", bus.rvalid, exp_rv);
    check("rdata", bus.rdata, exp_rd);
    check("err", bus.err, exp_er);

    for (int p = 0; p < P; p++) begin
      if (bus.rvalid[p]) begin
        last_rdata[p] = bus.rdata[p*W +: W];
        last_err[p]   = bus.err[p];
      end
      if (bus.ready[p]) grant_log.push_back(p);
    end

    acc = '0;
    if (win >= 0) begin
      acc[win] = 1'b1;
      a = int'(req_a[win*AW +: AW]);
      r.due = cycle + L;
      r.port = win;
      r.data = '0;
      r.err = 1'b0;
      if (a >= D) begin
        r.err = 1'b1;
      end else if (req_wr[win]) begin
        for (int b = 0; b < BW; b++)
          if (req_be[win*BW + b]) mdl[a][8*b +: 8] = req_d[win*W + 8*b +: 8];
      end else begin
        r.data = mdl[a];
      end
      q.push_back(r);
      rr_m = (win + 1) % P;
    end
    if (!res && init_left > 0) init_left--;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    res = 1'b1;
    q.delete();
    rr_m = 0;
    init_left = D;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic issue(input int p, input logic wr, input int a,
                       input logic [W-1:0] d, input logic [BW-1:0] b);
    req_v[p] = 1'b1;
    req_wr[p] = wr;
    req_a[p*AW +: AW] = AW'(a);
    req_d[p*W +: W] = d;
    req_be[p*BW +: BW] = b;
    for (int n = 0; n < 200; n++) begin
      step();
      if (acc[p]) break;
    end
    check("issue_accept", acc[p], 1'b1);
    req_v[p] = 1'b0;
  endtask

  task automatic drain();
    req_v = '0;
    repeat (L + 2) step();
  endtask

  initial begin
    for (int p = 0; p < P; p++) begin
      last_rdata[p] = 'x;
      last_err[p] = 1'bx;
    end
    // reset state, then INIT length observed with port 0 waiting
    do_reset();
    issue(0, 1'b0, 0, '0, '0);
    check("init_len", cycle, 2 + D + 1);
    for (int a = 1; a < D; a++) issue(0, 1'b0, a, '0, '0);
    drain();
    check("zero_fill_rd", last_rdata[0], 16'h0000);

    // partial byte-enable write
    issue(0, 1'b1, 5, 16'h1234, 2'b11);
    issue(0, 1'b1, 5, 16'hABCD, 2'b01);
    issue(0, 1'b0, 5, '0, '0);
    drain();
    check("be_merge", last_rdata[0], 16'h12CD);
    issue(0, 1'b1, 5, 16'hFFFF, 2'b00);
    issue(0, 1'b0, 5, '0, '0);
    drain();
    check("be_zero_noop", last_rdata[0], 16'h12CD);

    // write then read from the other port on the next edge
    issue(0, 1'b1, 9, 16'h5555, 2'b11);
    issue(1, 1'b0, 9, '0, '0);
    drain();
    check("wr_then_rd", last_rdata[1], 16'h5555);

    // both ports held for 6 cycles with pointer at 0
    grant_log.delete();
    req_v = 2'b11; req_wr = 2'b00;
    req_a = {AW'(2), AW'(1)};
    repeat (6) step();
    drain();
    check("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);

    // out-of-range accesses leave the array alone
    issue(0, 1'b1, 47, 16'h4747, 2'b11);
    issue(1, 1'b0, 50, '0, '0);
    issue(0, 1'b1, 63, 16'hFFFF, 2'b11);
    drain();
    check("oor_rd_err", last_err[1], 1'b1);
    check("oor_rd_data", last_rdata[1], 16'h0000);
    check("oor_wr_err", last_err[0], 1'b1);
    check("oor_wr_data", last_rdata[0], 16'h0000);
    issue(0, 1'b0, 47, '0, '0);
    drain();
    check("rd47_kept", last_rdata[0], 16'h4747);
    issue(1, 1'b0, 15, '0, '0);
    drain();
    check("rd15_no_alias", last_rdata[1], 16'h0000);
    check("rd15_err", last_err[1], 1'b0);

    // randomized traffic; unaccepted requests are held stable
    acc = '0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < P; p++) begin
        if (!req_v[p] || acc[p]) begin
          req_v[p] = ($urandom_range(0, 9) < 7);
          req_wr[p] = 1'($urandom_range(0, 1));
          req_a[p*AW +: AW] = AW'($urandom_range(0, 63));
          req_d[p*W +: W] = W'($urandom);
          req_be[p*BW +: BW] = BW'($urandom_range(0, 3));
        end
      end
      step();
    end
    drain();

    // reset with three reads in flight, then reset again during INIT
    issue(0, 1'b1, 5, 16'h7777, 2'b11);
    issue(1, 1'b1, 9, 16'h9999, 2'b11);
    issue(0, 1'b0, 5, '0, '0);
    issue(0, 1'b0, 9, '0, '0);
    issue(0, 1'b0, 5, '0, '0);
    do_reset();
    repeat (10) step();
    do_reset();
    issue(0, 1'b0, 5, '0, '0);
    issue(1, 1'b0, 9, '0, '0);
    drain();
    check("post_rst_rd5", last_rdata[0], 16'h0000);
    check("post_rst_rd9", last_rdata[1], 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/memory_arb.md
# memory_arb

Parametrised multi-port successor to the team's single-port valid/ready memory: a WIDTH x DEPTH storage array shared by PORTS request channels through round-robin arbitration. Adds byte-enable writes, a configurable read latency pipeline, out-of-range address error reporting, and a post-reset zero-fill sweep. It sits between several bus masters and a shared scratchpad, one access per clock.

## Interface

- WIDTH, 16, data width in bits; multiple of 8
- DEPTH, 64, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width
- PORTS, 2, number of request channels, 1..8
- RD_LAT, 1, response latency in cycles, 1..4

- clk  input  1  clock, all state on rising edge
- res  input  1  asynchronous active-high reset
- valid  input  PORTS  per-port request valid
- wr_rd  input  PORTS  per-port 1 = write, 0 = read
- addr  input  PORTS*ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  input  PORTS*WIDTH  per-port write data
- be  input  PORTS*WIDTH/8  per-port byte enables, bit i covers data bits [8i+7:8i]
- ready  output  PORTS  combinational grant; transfer on valid[p] & ready[p] at rising edge
- rvalid  output  PORTS  one-cycle response pulse per accepted transfer
- rdata  output  PORTS*WIDTH  read data, qualified by rvalid
- err  output  PORTS  address-error flag, qualified by rvalid

## Operation

- FSM states: INIT, RUN. res forces INIT, sweep counter 0, rr pointer 0, RD_LAT pipeline cleared.
- INIT: one word per cycle, mem[cnt] <= 0, cnt 0..DEPTH-1. Takes exactly DEPTH cycles after res deasserts, then moves to RUN. ready = 0 on all ports throughout INIT.
- RUN: at most one ready bit high per cycle. Winner is the first port with valid set, searching from rr pointer upward modulo PORTS. ready is 0 when no port has valid set.
- After a grant to port k, rr pointer <= (k+1) mod PORTS. Pointer is unchanged on idle cycles.
- Requesters hold valid, wr_rd, addr, wdata and be stable until accepted. The block does not sample unaccepted requests.
- Write, addr < DEPTH: for each set be bit i, mem[addr] byte i <= wdata byte i. Bytes with be clear are preserved. be = 0 is a legal no-op write.
- Read: returns mem[addr]; be is ignored.
- addr >= DEPTH, only possible for non-power-of-two DEPTH:
  - the array is not touched;
  - the response carries err = 1 and rdata = 0.
- Response for every accepted transfer, read or write, goes to the accepting port only:
  - rvalid = 1 for one cycle;
  - rdata = read data for in-range reads, 0 for writes;
  - err as above.
- Outside rvalid pulses, rdata and err read 0.

## Timing

- Reset values: ready = 0, rvalid = 0, rdata = 0, err = 0. Array contents are undefined until INIT completes.
- Transfer accepted at edge T: rvalid high in the cycle following edge T+RD_LAT-1. With RD_LAT = 1, rvalid is high in the cycle right after acceptance.
- Throughput: one accepted transfer per cycle across all ports. A single port with valid held continuously is accepted every cycle.
- Read data is the array value at the accepting edge:
  - a write accepted at edge T is visible to a read accepted at T+1;
  - a read and a write are never accepted at the same edge, because there is one grant per cycle.
- Back-to-back responses to one port appear on consecutive cycles, in acceptance order.
- Reset mid-operation: all in-flight responses are discarded with no rvalid, INIT restarts from address 0, and the array is fully re-zeroed.
- res asserted during INIT: the sweep restarts from 0.

## Test plan

- Reset then idle: ready = 0 for exactly DEPTH = 64 cycles after res falls. After INIT, a read of every address returns rdata = 0 and err = 0.
- Port 0 writes 0xABCD to addr 5 with be = 2'b01, after a prior full write of 0x1234: a later read of addr 5 returns 0x12CD, with rvalid exactly RD_LAT cycles after acceptance, for RD_LAT = 1 and RD_LAT = 3.
- PORTS = 2, both ports hold valid for 6 cycles: grants alternate 0,1,0,1,0,1 starting from port 0. Each port gets 3 responses in order.
- Write addr 9 = 0x5555 accepted, then read addr 9 accepted on the next edge from the other port: rdata = 0x5555.
- DEPTH = 48, read of addr 50 and write of addr 63: both responses carry err = 1 and rdata = 0. A read of addr 47 afterwards is unchanged.
- Assert res while 3 reads are in flight with RD_LAT = 4: no rvalid appears, INIT reruns, and previously written addresses read 0.
